add_sub_serial: RTL and testbench
=================================

Name: add_sub_serial

Overview:
- Parametrised, multi-cycle, digit-serial two's-complement adder/subtractor; next generation of the team's 4-bit ripple add/sub.
- Processes DIGIT bits per clock through a DIGIT-wide carry chain, carrying between cycles in a flop, so datapath width scales without a long ripple path.
- Adds valid/ready handshakes on both sides plus status flags: carry/borrow, signed overflow, zero, negative.
- Used as a shared ALU arithmetic unit wherever area matters more than throughput.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2 and an integer multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT is the number of compute cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  final carry out; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  s == 0.
- neg  output  1  s[WIDTH-1].

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE, count = 0, carry = 0, operand/result registers = 0. Outputs in_ready = 1, out_valid = 0, s = 0, cout = ovf = zero = neg = 0.
- States:
  - IDLE: in_ready = 1. When in_valid & in_ready at an edge: latch a, b, mode; carry ← mode; count ← 0; go to RUN.
  - RUN: in_ready = 0. Each edge processes digit d = count:
    - bits [d·DIGIT +: DIGIT] = A_d + (B_d XOR {DIGIT{mode}}) + carry.
    - Write the sum digit into the result register; carry ← digit carry-out; count ← count+1.
    - On the edge processing d = N−1: capture cout = final carry, ovf = carry into MSB XOR carry out of MSB, zero, neg; go to DONE.
  - DONE: out_valid = 1, in_ready = 0. s and flags held stable. On out_valid & out_ready go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises exactly N cycles after the accept edge (N = 4 at defaults). Minimum spacing between accepts is N+2 cycles.
- Arithmetic:
  - Subtract is A + ~B + 1: mode inverts B and seeds the initial carry.
  - No sign extension; all results wrap modulo 2^WIDTH.
- Boundary conditions:
  - Inputs a, b, mode are ignored outside the accept edge. Changes during RUN/DONE do not affect the result.
  - in_valid during RUN/DONE is not accepted; the producer must hold it.
  - out_ready held low: stay in DONE indefinitely with outputs stable.
  - out_ready high before out_valid has no effect.
  - DIGIT = WIDTH (N = 1): single RUN cycle; behaviour is otherwise identical.
  - rst asserted in any state, including mid-RUN or in DONE with out_ready low: the next edge forces reset values. The in-flight operation is discarded and no out_valid is produced for it.
  - rst and in_valid together: rst wins; nothing is accepted.

Test Plan (WIDTH=16, DIGIT=4 unless noted):
1. Add: a=0x1234, b=0x4321, mode=0 → out_valid exactly 4 cycles after accept; s=0x5555, cout=0, ovf=0, zero=0, neg=0.
2. Subtract with borrow: a=0x0005, b=0x0007, mode=1 → s=0xFFFE, cout=0, neg=1, ovf=0. Then a=0x0007, b=0x0005 → s=0x0002, cout=1.
3. Overflow and wrap:
   - Add 0x7FFF+0x0001 → s=0x8000, ovf=1, neg=1, cout=0.
   - Add 0xFFFF+0x0001 → s=0x0000, zero=1, cout=1, ovf=0.
   - Subtract 0x8000−0x0001 → s=0x7FFF, ovf=1, cout=1.
4. Backpressure:
   - Hold out_ready=0 for 6 cycles after out_valid → s and flags unchanged; in_ready=0.
   - A new in_valid with a=0x1111 is not accepted.
   - Raise out_ready → IDLE next cycle; the pending request is then accepted and returns 0x1111+b correctly.
   - Change a/b during RUN → result unaffected.
5. Reset mid-operation: assert rst on the 2nd RUN cycle → next cycle in_ready=1, out_valid=0, s=0. A subsequent 0x00FF+0x0001 yields 0x0100 with no stale output.
6. Parameter sweep:
   - DIGIT=1, WIDTH=8: 0x7F+0x01 → 0x80, ovf=1, latency 8 cycles.
   - DIGIT=WIDTH=8: same operation with latency 1 cycle.
   - Random back-to-back operations against a behavioural A±B model, random out_ready.

Source files
------------

// File: rtl/add_sub_serial.sv
// -----------------------------------------------------------------------------
// add_sub_serial
//   Digit-serial two's-complement adder/subtractor. Each operation takes
//   N = WIDTH/DIGIT compute cycles. Every cycle one DIGIT-wide slice goes
//   through a short carry chain, and a flop holds the carry for the next
//   cycle. Valid/ready handshakes sit on the input and output sides. The
//   flags carry/borrow, signed overflow, zero and negative are registered
//   along with the result.
//
//   WIDTH must be >= 2 and an integer multiple of DIGIT (1 <= DIGIT <= WIDTH).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand request valid
//   in_ready   block is idle and can accept an operation
//   a, b       operands (sampled only on the accept edge)
//   mode       0 = a + b, 1 = a - b
//   out_valid  result and flags valid (held until out_ready)
//   out_ready  consumer accepts the result
//   s          result, modulo 2^WIDTH
//   cout       final carry out; for subtract 1 = no borrow (a >= b unsigned)
//   ovf        signed overflow
//   zero       s == 0
//   neg        s[WIDTH-1]
// -----------------------------------------------------------------------------
module add_sub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] count;
    logic             carry;
    logic             mode_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic             neg_reg;

    // ------------------------------------------------------------------
    // Digit datapath. The operand registers shift right one digit per RUN
    // cycle, so the current digit is always in the low DIGIT bits. Each
    // sum digit enters the result register at the top and shifts down.
    // After N cycles digit 0 sits in bits [DIGIT-1:0].
    // ------------------------------------------------------------------
    logic [DIGIT-1:0]       a_dig;
    logic [DIGIT-1:0]       b_dig;
    logic [DIGIT:0]         dig_sum;
    logic [WIDTH+DIGIT-1:0] s_shift;
    logic [WIDTH-1:0]       s_upd;
    logic                   msb_cin;
    logic                   last_digit;

    assign a_dig   = a_reg[DIGIT-1:0];
    // Subtract is a + ~b + 1. The +1 comes from the carry seed at accept.
    assign b_dig   = b_reg[DIGIT-1:0] ^ {DIGIT{mode_reg}};
    assign dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    assign s_shift = {dig_sum[DIGIT-1:0], s_reg} >> DIGIT;
    assign s_upd   = s_shift[WIDTH-1:0];

    // The carry into the top bit of the last digit can be recovered from
    // that bit's sum: sum = a ^ b ^ cin.
    assign msb_cin    = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1];
    assign last_digit = (count == CNT_W'(N - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so that every
        // flop samples the pre-edge values, independent of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first. Otherwise a
        // path that skips an assignment would infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and result registers are reset as well,
            // because s and the flags are visible outputs that must read 0
            // after reset.
            count    <= '0;
            carry    <= 1'b0;
            mode_reg <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        mode_reg <= mode;
                        carry    <= mode;
                        count    <= '0;
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    s_reg <= s_upd;
                    carry <= dig_sum[DIGIT];
                    count <= count + CNT_W'(1);
                    if (last_digit) begin
                        cout_reg <= dig_sum[DIGIT];
                        ovf_reg  <= msb_cin ^ dig_sum[DIGIT];
                        zero_reg <= (s_upd == '0);
                        neg_reg  <= dig_sum[DIGIT-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = s_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
    assign zero = zero_reg;
    assign neg  = neg_reg;

endmodule

// File: tb/tb_add_sub_serial.sv
// -----------------------------------------------------------------------------
// tb_add_sub_serial
//   Directed bench for add_sub_serial. The main instance uses WIDTH=16,
//   DIGIT=4. Two 8-bit instances (DIGIT=1 and DIGIT=8) cover the extreme
//   digit sizes. Expected values are computed by hand, or by a small
//   behavioural a +/- b model for the random block.
// -----------------------------------------------------------------------------
module tb_add_sub_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout, ovf, zero, neg;

    // shared inputs for the two 8-bit instances
    logic        in_valid8, out_ready8, mode8;
    logic [7:0]  a8, b8;
    logic        d1_in_ready, d1_out_valid, d1_cout, d1_ovf, d1_zero, d1_neg;
    logic [7:0]  d1_s;
    logic        d8_in_ready, d8_out_valid, d8_cout, d8_ovf, d8_zero, d8_neg;
    logic [7:0]  d8_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_sub_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    add_sub_serial #(.WIDTH(8), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(d1_in_ready),
        .a(a8), .b(b8), .mode(mode8), .out_valid(d1_out_valid), .out_ready(out_ready8),
        .s(d1_s), .cout(d1_cout), .ovf(d1_ovf), .zero(d1_zero), .neg(d1_neg)
    );

    add_sub_serial #(.WIDTH(8), .DIGIT(8)) dut_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(d8_in_ready),
        .a(a8), .b(b8), .mode(mode8), .out_valid(d8_out_valid), .out_ready(out_ready8),
        .s(d8_s), .cout(d8_cout), .ovf(d8_ovf), .zero(d8_zero), .neg(d8_neg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid on the main instance; lat = edges waited.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic scramble();
        a    = 16'($urandom);
        b    = 16'($urandom);
        mode = 1'($urandom);
    endtask

    // One full transaction on the main instance. The operands are scrambled
    // after the accept edge. early_rdy raises out_ready before out_valid.
    // hold keeps out_ready low for that many cycles once out_valid is up.
    task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic im, input logic early_rdy, input int hold,
                          input logic [15:0] es, input logic ec, input logic eo,
                          input logic ez, input logic en);
        int lat;
        check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
        a = ia; b = ib; mode = im; in_valid = 1'b1;
        out_ready = early_rdy;
        tick();
        in_valid = 1'b0;
        scramble();
        wait_valid(lat);
        check({tag, " latency"}, 32'(lat), 32'd4);
        if (!early_rdy) begin
            repeat (hold) tick();
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " s"},    32'(s),    32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " ovf"},  32'(ovf),  32'(eo));
        check({tag, " zero"}, 32'(zero), 32'(ez));
        check({tag, " neg"},  32'(neg),  32'(en));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat, lat1, lat8;
        logic [15:0] ra, rb, bb, es;
        logic [16:0] full;
        logic        rm;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
        tick(); tick();
        rst = 1'b0;

        // ---------------- reset state ----------------
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst s",         32'(s),         32'd0);
        check("rst flags",     32'({cout, ovf, zero, neg}), 32'd0);

        // ---------------- basic add / subtract ----------------
        run_op("add",     16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub5m7",  16'h0005, 16'h0007, 1'b1, 1'b0, 0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub7m5",  16'h0007, 16'h0005, 1'b1, 1'b1, 0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);

        // ---------------- overflow and wrap ----------------
        run_op("ovf add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("ovf sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // ---------------- backpressure ----------------
        a = 16'h2222; b = 16'h0101; mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'd4);
        check("bp s", 32'(s), 32'h2323);
        a = 16'h1111; b = 16'h0022; mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp hold s",         32'(s),         32'h2323);
            check("bp hold flags",     32'({cout, ovf, zero, neg}), 32'd0);
            check("bp hold out_valid", 32'(out_valid), 32'd1);
            check("bp hold in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready",  32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        scramble();
        check("bp pending accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("bp pending latency", 32'(lat), 32'd4);
        check("bp pending s", 32'(s), 32'h1133);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---------------- reset mid-operation ----------------
        a = 16'h1234; b = 16'h0001; mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();                       // now in the second RUN cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst in_ready",  32'(in_ready),  32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst s",         32'(s),         32'd0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) lat++;
        end
        check("midrst no stale valid", 32'(lat), 32'd0);
        run_op("after rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

        // rst and in_valid together: nothing is accepted
        a = 16'h0003; b = 16'h0004; in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst+valid in_ready", 32'(in_ready), 32'd1);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) lat++;
        end
        check("rst+valid no result", 32'(lat), 32'd0);

        // ---------------- digit-size sweep (WIDTH=8) ----------------
        check("d1 in_ready", 32'(d1_in_ready), 32'd1);
        check("d8 in_ready", 32'(d8_in_ready), 32'd1);
        a8 = 8'h7F; b8 = 8'h01; mode8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        a8 = 8'hAA; b8 = 8'h55; mode8 = 1'b1;
        lat1 = -1; lat8 = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (lat1 < 0 && d1_out_valid === 1'b1) lat1 = c;
            if (lat8 < 0 && d8_out_valid === 1'b1) lat8 = c;
        end
        check("d1 latency", 32'(lat1), 32'd8);
        check("d8 latency", 32'(lat8), 32'd1);
        check("d1 s", 32'(d1_s), 32'h80);
        check("d8 s", 32'(d8_s), 32'h80);
        check("d1 flags c/o/z/n", 32'({d1_cout, d1_ovf, d1_zero, d1_neg}), 32'b0101);
        check("d8 flags c/o/z/n", 32'({d8_cout, d8_ovf, d8_zero, d8_neg}), 32'b0101);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check("d1 out_valid drop", 32'(d1_out_valid), 32'd0);
        check("d8 out_valid drop", 32'(d8_out_valid), 32'd0);

        // ---------------- random back-to-back vs behavioural model ----------------
        for (int i = 0; i < 20; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rm   = 1'($urandom);
            bb   = rm ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, bb} + {16'd0, rm};
            es   = full[15:0];
            run_op("rand", ra, rb, rm, 1'($urandom), int'($urandom_range(0, 3)), es, full[16],
                   (ra[15] == bb[15]) && (es[15] != ra[15]), es == 16'd0, es[15]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
